turf_generic_link: RTL and testbench
====================================

Name: turf_generic_link

Overview:
Downstream stage of the 2-port TURF generic arbiter. Consumes the arbitrated generic master port (en/wr/ack, 28-bit address, 32-bit data). Serializes each transaction into a byte-wide command packet toward the TURF link, then parses the byte-wide response back into a generic ack and read data. A response watchdog guarantees that every accepted transaction is acked.

Parameters:
TIMEOUT_CYCLES, 65536, WAIT_RSP cycles without an rx byte before the transaction is force-completed (minimum 2)
TIMEOUT_DATA, 32'hDEADBEEF, value returned on s_dat_o for a timed-out transaction

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  asynchronous, active-low reset; 0 = reset asserted
s_en_i  in  1  request from arbiter m_en_o; held high until ack
s_wr_i  in  1  1 = write, 0 = read
s_ack_o  out  1  one-cycle completion pulse
s_adr_i  in  28  word address
s_dat_i  in  32  write data
s_dat_o  out  32  read data; valid with s_ack_o, held until the next ack
tx_data_o  out  8  command byte
tx_valid_o  out  1  command byte valid
tx_ready_i  in  1  link accepts the byte
rx_data_i  in  8  response byte
rx_valid_i  in  1  response byte strobe; always accepted, no backpressure
err_o  out  1  sticky timeout flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset values: s_ack_o=0, s_dat_o=0, tx_valid_o=0, tx_data_o=0, err_o=0. FSM=IDLE, counters=0.
- Reset asserted mid-transaction aborts immediately. The partial packet is abandoned and no ack is issued.
- States: IDLE, HDR, ADR, WDAT, WAIT_RSP, ACK.
- IDLE:
  - If s_en_i=1, latch wr/adr/dat and go to HDR.
  - rx bytes received in IDLE are discarded.
- HDR: tx_data_o = {wr, 3'b000, adr[27:24]}.
- ADR: three bytes, adr[23:16], adr[15:8], adr[7:0].
- WDAT: writes only; four bytes, dat[31:24] first (big-endian).
- Byte advance rule:
  - A byte advances only when tx_valid_o && tx_ready_i.
  - tx_data_o is stable while tx_valid_o && !tx_ready_i.
  - tx_valid_o stays high across consecutive bytes of a packet.
- Packet completion:
  - The last accepted byte goes to WAIT_RSP and clears the byte counter and the timer.
  - Packet length is 4 bytes for a read, 8 bytes for a write.
- WAIT_RSP:
  - Read: expects 4 rx bytes, MSB first, assembled into a shift register.
  - Write: expects 1 rx byte; its value is ignored.
  - The timer increments every cycle and clears on every rx byte.
  - Last expected rx byte → ACK, with s_dat_o = assembled word (read) or unchanged (write).
  - Timer reaching TIMEOUT_CYCLES-1 → ACK, with s_dat_o = TIMEOUT_DATA (read) or unchanged (write), and err_o set.
  - A last byte arriving in the same cycle as the timeout counts as success.
- ACK: s_ack_o=1 for exactly one cycle, then IDLE. s_en_i is not sampled in ACK. Minimum gap between transactions is one IDLE cycle, which lets the arbiter re-grant.
- Latency, en seen in IDLE at cycle N with tx_ready_i=1:
  - Header on tx at N+1.
  - Last command byte at N+4 (read) or N+8 (write).
  - Last rx byte at cycle M → s_ack_o at M+1.
- s_en_i dropping mid-transaction is a master protocol violation. It is ignored and the transaction completes normally.
- err_o: set on timeout, cleared by err_clr_i. Set wins if both occur in the same cycle.
- Timer width is $clog2(TIMEOUT_CYCLES). Wrap-around is impossible because the timeout fires first.

Decomposition:
- Package turf_link_pkg:
  - state enum
  - header field positions (HDR_WR_BIT=7, HDR_ADR_MSB=3)
  - RD_CMD_LEN=4, WR_CMD_LEN=8
  - RD_RSP_LEN=4, WR_RSP_LEN=1
- Sub-module turf_link_timer: loadable/clearable watchdog counter with a registered expiry pulse.

Test Plan:
- Write adr=28'h123_4567, dat=32'hCAFEF00D, tx_ready=1 → tx bytes 81,23,45,67,CA,FE,F0,0D on cycles N+1..N+8; rx byte 00 at M → s_ack_o pulse at M+1; err_o stays 0.
- Read adr=28'h0AB_CDEF, tx_ready toggling 1/0 → tx bytes 00,AB,CD,EF each held stable while stalled; rx 12,34,56,78 → ack with s_dat_o=32'h12345678.
- Read with no response, TIMEOUT_CYCLES=16 → ack 16 cycles after WAIT_RSP entry; s_dat_o=32'hDEADBEEF; err_o=1 until err_clr_i. Repeat with err_clr_i coincident with the timeout → err_o=1.
- Stray rx bytes in IDLE, then a read → stray bytes ignored; s_dat_o equals only the 4 post-command bytes.
- rst driven low during ADR of a write → tx_valid_o=0 and FSM in IDLE immediately; no ack issued; the next transaction after release is correct.
- Back-to-back requests with s_en_i held high → exactly one ack per transaction, with ≥1 IDLE cycle between ack and the next header.

Source files
------------

// File: rtl/turf_link_pkg.sv
// TURF link shared types: FSM states, header layout,
// command/response packet lengths.
package turf_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ADR,
    WDAT,
    WAIT_RSP,
    ACK
  } state_t;

  localparam int HDR_WR_BIT  = 7;
  localparam int HDR_ADR_MSB = 3;

  localparam int RD_CMD_LEN = 4;
  localparam int WR_CMD_LEN = 8;
  localparam int RD_RSP_LEN = 4;
  localparam int WR_RSP_LEN = 1;

  function automatic logic [7:0] hdr_byte(
    input logic       wr,
    input logic [3:0] adr_hi
  );
    logic [7:0] b;
    b = '0;
    b[HDR_WR_BIT] = wr;
    b[HDR_ADR_MSB:0] = adr_hi;
    return b;
  endfunction

endpackage

// File: rtl/turf_link_timer.sv
// Response watchdog: counts while run, clr zeroes it.
// Ports: clk, rst (async low), clr, run, expire (registered).
module turf_link_timer #(
  parameter int CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(CYCLES);

  logic [W-1:0] cnt;

  // expire is registered one count early so it is high
  // exactly while cnt == CYCLES-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (run) begin
      cnt    <= cnt + 1'b1;
      expire <= (cnt == W'(CYCLES - 2));
    end
  end

endmodule

// File: rtl/turf_generic_link.sv
// Generic master port to byte-wide TURF link bridge.
// Ports: s_* generic slave, tx_*/rx_* link bytes, err_o.
module turf_generic_link
  import turf_link_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 65536,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_en_i,
  input  logic        s_wr_i,
  output logic        s_ack_o,
  input  logic [27:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        err_o,
  input  logic        err_clr_i
);

  state_t      state;
  state_t      nxt;
  logic        wr_q;
  logic [27:0] adr_q;
  logic [31:0] dat_q;
  logic [2:0]  bcnt;
  logic [23:0] sreg;
  logic        fire;
  logic        cmd_last;
  logic        rsp_last;
  logic        tmo;
  logic        in_wait;

  assign in_wait = (state == WAIT_RSP);
  assign fire    = tx_valid_o && tx_ready_i;

  assign cmd_last =
    (state == ADR && !wr_q &&
     bcnt == 3'(RD_CMD_LEN - 1)) ||
    (state == WDAT &&
     bcnt == 3'(WR_CMD_LEN - 1));

  assign rsp_last = in_wait && rx_valid_i &&
    (bcnt == (wr_q ? 3'(WR_RSP_LEN - 1)
                   : 3'(RD_RSP_LEN - 1)));

  turf_link_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_wait || rx_valid_i),
    .run   (in_wait),
    .expire(tmo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt        = state;
    tx_valid_o = 1'b0;
    s_ack_o    = 1'b0;
    unique case (state)
      IDLE: if (s_en_i) nxt = HDR;
      HDR: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) nxt = ADR;
      end
      ADR: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i && bcnt == 3'd3)
          nxt = wr_q ? WDAT : WAIT_RSP;
      end
      WDAT: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i && cmd_last)
          nxt = WAIT_RSP;
      end
      WAIT_RSP: if (rsp_last || tmo) nxt = ACK;
      ACK: begin
        s_ack_o = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // bcnt indexes the whole packet: 0 header,
  // 1..3 address, 4..7 write data.
  always_comb begin
    tx_data_o = '0;
    if (tx_valid_o) begin
      unique case (bcnt)
        3'd0: tx_data_o = hdr_byte(wr_q, adr_q[27:24]);
        3'd1: tx_data_o = adr_q[23:16];
        3'd2: tx_data_o = adr_q[15:8];
        3'd3: tx_data_o = adr_q[7:0];
        3'd4: tx_data_o = dat_q[31:24];
        3'd5: tx_data_o = dat_q[23:16];
        3'd6: tx_data_o = dat_q[15:8];
        3'd7: tx_data_o = dat_q[7:0];
        default: tx_data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      bcnt    <= '0;
      sreg    <= '0;
      s_dat_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (state == IDLE && s_en_i) begin
        wr_q  <= s_wr_i;
        adr_q <= s_adr_i;
        dat_q <= s_dat_i;
      end
      if (fire)
        bcnt <= cmd_last ? 3'd0 : bcnt + 3'd1;
      if (in_wait && rx_valid_i) begin
        bcnt <= bcnt + 3'd1;
        sreg <= {sreg[15:0], rx_data_i};
      end
      // A last byte coinciding with expiry wins.
      if (in_wait && (rsp_last || tmo)) begin
        bcnt <= '0;
        if (!wr_q)
          s_dat_o <= rsp_last ? {sreg, rx_data_i}
                              : TIMEOUT_DATA;
      end
      if (in_wait && tmo && !rsp_last)
        err_o <= 1'b1;
      else if (err_clr_i)
        err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turf_generic_link.sv
// Scoreboard bench for turf_generic_link.
// Expected tx bytes and ack data are queued then popped.
module tb_turf_generic_link;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_en = 1'b0;
  logic        s_wr = 1'b0;
  logic        s_ack;
  logic [27:0] s_adr = '0;
  logic [31:0] s_dat_w = '0;
  logic [31:0] s_dat_r;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  turf_generic_link #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_DATA  (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_en_i    (s_en),
    .s_wr_i    (s_wr),
    .s_ack_o   (s_ack),
    .s_adr_i   (s_adr),
    .s_dat_i   (s_dat_w),
    .s_dat_o   (s_dat_r),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .err_o     (err),
    .err_clr_i (err_clr)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_ack = 0;
  int ack_cyc = 0;
  bit ack_seen = 0;
  bit ready_mode = 0;
  bit stall_pend = 0;
  logic [7:0]  held = '0;
  logic [31:0] exp_dat = '0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_ack[$];
  int          acc_log[$];

  // Observe the cycle (outputs settled, inputs applied),
  // then advance one clock.
  task automatic tick();
    logic [7:0]  e;
    logic [31:0] d;
    if (stall_pend && tx_valid) begin
      tests++;
      if (tx_data !== held) begin
        fails++;
        $display("FAIL tx_stable: got %h want %h", tx_data, held);
      end
    end
    stall_pend = tx_valid && !tx_ready;
    held = tx_data;
    if (tx_valid && tx_ready) begin
      acc_log.push_back(cyc);
      tests++;
      if (exp_tx.size() == 0) begin
        fails++;
        $display("FAIL tx_extra: got %h want none", tx_data);
      end else begin
        e = exp_tx.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_byte: got %h want %h", tx_data, e);
        end
      end
    end
    if (s_ack) begin
      ack_seen = 1;
      ack_cyc = cyc;
      n_ack++;
      tests++;
      if (exp_ack.size() == 0) begin
        fails++;
        $display("FAIL ack_extra: got ack want none");
      end else begin
        d = exp_ack.pop_front();
        if (s_dat_r !== d) begin
          fails++;
          $display("FAIL ack_dat: got %h want %h", s_dat_r, d);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    tx_ready = ready_mode ? ~tx_ready : 1'b1;
  endtask

  task automatic start(input logic wr, input logic [27:0] adr,
                       input logic [31:0] dat);
    s_en = 1'b1;
    s_wr = wr;
    s_adr = adr;
    s_dat_w = dat;
    exp_tx.push_back({wr, 3'b000, adr[27:24]});
    exp_tx.push_back(adr[23:16]);
    exp_tx.push_back(adr[15:8]);
    exp_tx.push_back(adr[7:0]);
    if (wr) begin
      exp_tx.push_back(dat[31:24]);
      exp_tx.push_back(dat[23:16]);
      exp_tx.push_back(dat[15:8]);
      exp_tx.push_back(dat[7:0]);
    end
  endtask

  task automatic send_all(input string tag);
    int k = 0;
    while (exp_tx.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    tests++;
    if (exp_tx.size() != 0) begin
      fails++;
      $display("FAIL %s_cmd: %0d bytes left want 0", tag, exp_tx.size());
      exp_tx.delete();
    end
  endtask

  task automatic rsp(input logic [31:0] w, input int n,
                     output int m);
    m = cyc;
    for (int i = 0; i < n; i++) begin
      rx_data = w[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      m = cyc;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input bit keep,
                          output int a);
    int k = 0;
    ack_seen = 0;
    while (!ack_seen && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (!ack_seen) begin
      fails++;
      $display("FAIL %s_ack: got no ack want ack", tag);
    end
    a = ack_cyc;
    if (!keep) s_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({s_ack, tx_valid, err, tx_data, s_dat_r} !== '0) begin
      fails++;
      $display("FAIL reset_out: got %b/%b/%b/%h/%h want 0",
               s_ack, tx_valid, err, tx_data, s_dat_r);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_write();
    int n, m, a;
    ready_mode = 0;
    acc_log.delete();
    n = cyc;
    start(1'b1, 28'h1234567, 32'hCAFEF00D);
    send_all("wr");
    tests++;
    if (acc_log.size() != 8 || acc_log[0] != n + 1 ||
        acc_log[acc_log.size()-1] != n + 8) begin
      fails++;
      $display("FAIL wr_lat: got %0d bytes first %0d want 8 from %0d",
               acc_log.size(), acc_log[0] - n, 1);
    end
    tick();
    tick();
    exp_ack.push_back(exp_dat);
    rsp(32'h0, 1, m);
    wait_ack("wr", 0, a);
    tests++;
    if (a != m + 1) begin
      fails++;
      $display("FAIL wr_ack_lat: got %0d want %0d", a - m, 1);
    end
    tests++;
    if (s_ack !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL wr_post: got ack %b err %b want 0 0", s_ack, err);
    end
    tick();
  endtask

  task automatic test_read_stall();
    int m, a;
    ready_mode = 1;
    start(1'b0, 28'h0ABCDEF, 32'h0);
    send_all("rd");
    ready_mode = 0;
    tx_ready = 1'b1;
    exp_dat = 32'h12345678;
    exp_ack.push_back(exp_dat);
    rsp(32'h12345678, 4, m);
    wait_ack("rd", 0, a);
    tests++;
    if (a != m + 1) begin
      fails++;
      $display("FAIL rd_ack_lat: got %0d want %0d", a - m, 1);
    end
    tick();
  endtask

  task automatic test_timeout();
    int l, a;
    acc_log.delete();
    start(1'b0, 28'h0000100, 32'h0);
    send_all("to");
    l = acc_log[acc_log.size()-1];
    exp_dat = 32'hDEADBEEF;
    exp_ack.push_back(exp_dat);
    wait_ack("to", 0, a);
    tests++;
    if (a != l + 17) begin
      fails++;
      $display("FAIL to_lat: got %0d want %0d", a - l - 1, 16);
    end
    tick();
    tick();
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL to_err: got %b want 1", err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL to_clr: got %b want 0", err);
    end
    acc_log.delete();
    start(1'b0, 28'h0000200, 32'h0);
    send_all("to2");
    l = acc_log[acc_log.size()-1];
    exp_ack.push_back(exp_dat);
    while (cyc < l + 16) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (s_ack !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL to_setwins: got ack %b err %b want 1 1", s_ack, err);
    end
    wait_ack("to2", 0, a);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_stray_rx();
    int m, a;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hA0 + 8'(i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    start(1'b0, 28'h0000010, 32'h0);
    send_all("stray");
    exp_dat = 32'h11223344;
    exp_ack.push_back(exp_dat);
    rsp(32'h11223344, 4, m);
    wait_ack("stray", 0, a);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL stray_err: got %b want 0", err);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int k = 0;
    int k0, m, a;
    acc_log.delete();
    start(1'b1, 28'hFEDCBA9, 32'h55AA55AA);
    while (acc_log.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (tx_valid !== 1'b0 || s_ack !== 1'b0 || s_dat_r !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid: got v %b ack %b dat %h want 0 0 0",
               tx_valid, s_ack, s_dat_r);
    end
    exp_tx.delete();
    stall_pend = 0;
    exp_dat = 32'h0;
    s_en = 1'b0;
    k0 = n_ack;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (n_ack != k0 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_noack: got %0d acks want 0", n_ack - k0);
    end
    start(1'b0, 28'h0000ABC, 32'h0);
    send_all("rst_rd");
    exp_dat = 32'hF00DF00D;
    exp_ack.push_back(exp_dat);
    rsp(32'hF00DF00D, 4, m);
    wait_ack("rst_rd", 0, a);
    tick();
  endtask

  task automatic test_back_to_back();
    int m, a, k0;
    k0 = n_ack;
    start(1'b0, 28'h0000001, 32'h0);
    send_all("b2b1");
    exp_dat = 32'hA1A2A3A4;
    exp_ack.push_back(exp_dat);
    rsp(32'hA1A2A3A4, 4, m);
    wait_ack("b2b1", 1, a);
    acc_log.delete();
    start(1'b1, 28'h0000002, 32'h01020304);
    send_all("b2b2");
    tests++;
    if (acc_log[0] != a + 2) begin
      fails++;
      $display("FAIL b2b_gap: got %0d want %0d", acc_log[0] - a, 2);
    end
    exp_ack.push_back(exp_dat);
    rsp(32'h0, 1, m);
    wait_ack("b2b2", 0, a);
    repeat (3) tick();
    tests++;
    if (n_ack - k0 != 2 || exp_ack.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: got %0d acks want 2", n_ack - k0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_timeout();
    test_stray_rx();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
